slvds_t: RTL and testbench
==========================

SLVDS_T -- requirements
Module: slvds_t

Interface
REQ-001 Parameter SYNC_LEN, default 24, number of low bits driven after reset; SHALL be at least 20.
REQ-002 Parameter GAP_LEN, default 0, number of low idle bits inserted after each frame.
REQ-003 clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 din  input  16  parallel word to serialize; sampled only on acceptance.
REQ-006 valid  input  1  din holds a word to send.
REQ-007 ready  output  1  block accepts a word this cycle.
REQ-008 out  output  1  registered serial line toward the slvds receiver.
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 States SHALL be SYNC, IDLE, SHIFT and GAP, with SYNC entered on reset.
REQ-011 SYNC: out=0 for exactly SYNC_LEN cycles, ready=0, valid ignored, then go to IDLE.
REQ-012 IDLE: out=0 and ready=1.
REQ-013 Acceptance SHALL occur when valid=1 and ready=1 in the same cycle; din is captured into a 16-bit holding register and the state goes to SHIFT.
REQ-014 Frame SHALL be 20 bits, one per clk, first bit on out in the cycle after acceptance (latency 1).
REQ-015 Frame offsets after acceptance: k=1,2 -> 1 (start pair); k=3..18 -> din[0]..din[15] (LSB first); k=19 -> trailer0; k=20 -> trailer1=0.
REQ-016 A 5-bit bit counter SHALL index the frame; it is cleared on acceptance and the frame ends at count 20.
REQ-017 After bit 20, go to GAP when GAP_LEN>0 (out=0 for GAP_LEN cycles), else go to IDLE.
REQ-018 When GAP_LEN=0, ready SHALL also be 1 during the k=20 cycle, so an acceptance there starts the next frame's start bit with no idle bit (back-to-back).
REQ-019 ready SHALL be 0 throughout SHIFT except REQ-018, and throughout GAP; valid without ready SHALL have no effect.
REQ-020 out SHALL be 0 in every cycle not carrying a frame bit, so the receiver never sees a false "11" start pair.
REQ-021 din changes after acceptance SHALL NOT affect the frame in flight.

Reset
REQ-022 rst=1 SHALL give, on the next edge: out=0, ready=0, busy=1, counters cleared, holding register 0, state SYNC.
REQ-023 rst during SHIFT or GAP SHALL abort the frame with no further frame bits, then run a full SYNC_LEN preamble.
REQ-024 rst held high SHALL hold the block in the reset values; SYNC counting begins the cycle after rst falls.

Configuration
REQ-025 Macro SLVDS_T_PARITY_EN defined: trailer0 = XOR of din[15:0] (even parity over data plus trailer0).
REQ-026 Macro SLVDS_T_PARITY_EN undefined: trailer0 = 0; no parity logic is built.
REQ-027 trailer1 SHALL be 0 in both builds.

Verification
REQ-028 Release rst, valid=1 from start -> out=0 and ready=0 for 24 cycles, ready=1 on cycle 25, first accept then.
REQ-029 Send din=16'hA5C3 -> out sequence 1,1,1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1,t0,0; with PARITY_EN t0=0 (eight ones).
REQ-030 PARITY_EN, din=16'h0001 -> trailer0=1; no PARITY_EN -> trailer0=0; paired slvds receiver presents out[1:0]=01 and 00.
REQ-031 GAP_LEN=0, valid held high with words 16'h1234, 16'hFFFF -> frames are adjacent (40 consecutive bits); receiver dv pulses show 16'h1234 then 16'hFFFF.
REQ-032 GAP_LEN=3 -> exactly 3 zero bits between frames; ready=0 during them.
REQ-033 rst asserted at frame bit k=10 -> out=0 next cycle, then 24 zero cycles, then a new frame is accepted; the receiver outputs no word for the aborted frame.

Source files
------------

// File: rtl/slvds_t.sv
// rtl/slvds_t.sv - 16-bit word serializer for the slvds line (frame: 11, data LSB first, trailer0, 0)
// Optional build macro: SLVDS_T_PARITY_EN (trailer0 = even parity over the data word).
module slvds_t #(
  parameter int SYNC_LEN = 24,
  parameter int GAP_LEN  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        valid,
  output logic        ready,
  output logic        out,
  output logic        busy
);

  localparam int SW = $clog2(SYNC_LEN + 1);
  localparam int GW = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [4:0]    LAST_BIT  = 5'd20;

  typedef enum logic [1:0] {SYNC, IDLE, SHIFT, GAP} state_t;

  state_t        state;
  state_t        state_nx;
  logic [SW-1:0] sync_cnt;
  logic [GW-1:0] gap_cnt;
  logic [4:0]    bit_cnt;   // index (1..20) of the frame bit currently on out
  logic [15:0]   hold;
  logic          accept;
  logic          trailer0;
  logic          next_bit;
  logic [3:0]    data_idx;

`ifdef SLVDS_T_PARITY_EN
  assign trailer0 = ^hold;
`else
  assign trailer0 = 1'b0;
`endif

  assign accept   = valid & ready;
  assign busy     = (state != IDLE);
  // bit_cnt 2..17 selects data bit 0..15 for the following cycle; the 4-bit wrap gives 16->14, 17->15
  assign data_idx = bit_cnt[3:0] - 4'd2;

  // Frame bit that follows the one currently on out
  always_comb begin
    next_bit = 1'b0;
    if (bit_cnt == 5'd1) begin
      next_bit = 1'b1;
    end else if (bit_cnt >= 5'd2 && bit_cnt <= 5'd17) begin
      next_bit = hold[data_idx];
    end else if (bit_cnt == 5'd18) begin
      next_bit = trailer0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SYNC;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and ready; the last frame bit doubles as an accept slot when no gap is configured
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      SYNC: begin
        if (sync_cnt == SYNC_LAST) state_nx = IDLE;
      end
      IDLE: begin
        ready = 1'b1;
        if (valid) state_nx = SHIFT;
      end
      SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          if (GAP_LEN == 0) begin
            ready    = 1'b1;
            state_nx = valid ? SHIFT : IDLE;
          end else begin
            state_nx = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nx = IDLE;
      end
      default: state_nx = SYNC;
    endcase
  end

  // Counters, holding register and the registered serial line; out is low unless a frame bit is due
  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= 1'b0;
      bit_cnt  <= 5'd0;
      sync_cnt <= '0;
      gap_cnt  <= '0;
      hold     <= 16'h0000;
    end else begin
      sync_cnt <= (state == SYNC) ? sync_cnt + 1'b1 : '0;
      gap_cnt  <= (state == GAP)  ? gap_cnt + 1'b1  : '0;
      if (accept) begin
        hold    <= din;
        bit_cnt <= 5'd1;
        out     <= 1'b1;
      end else if (state == SHIFT && bit_cnt != LAST_BIT) begin
        bit_cnt <= bit_cnt + 5'd1;
        out     <= next_bit;
      end else begin
        out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_slvds_t.sv
// tb/tb_slvds_t.sv - self-checking bench for slvds_t (GAP_LEN=0 and GAP_LEN=3 instances side by side)
module tb_slvds_t;

  localparam int SYNC = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] din;
  logic        ready0, out0, busy0;
  logic        ready3, out3, busy3;

  int checks = 0;
  int errors = 0;

  slvds_t #(.SYNC_LEN(SYNC), .GAP_LEN(0)) dut0 (
    .clk(clk), .rst(rst), .din(din), .valid(valid),
    .ready(ready0), .out(out0), .busy(busy0)
  );

  slvds_t #(.SYNC_LEN(SYNC), .GAP_LEN(3)) dut3 (
    .clk(clk), .rst(rst), .din(din), .valid(valid),
    .ready(ready3), .out(out3), .busy(busy3)
  );

  always #5 clk = ~clk;

  // Frame contents as a vector: bit k-1 holds frame bit k
  function automatic logic [19:0] frame_of(input logic [15:0] w);
    logic t0;
`ifdef SLVDS_T_PARITY_EN
    t0 = ^w;
`else
    t0 = 1'b0;
`endif
    return {1'b0, t0, w, 2'b11};
  endfunction

  function automatic logic [19:0] pack(input int b[20]);
    logic [19:0] v;
    for (int k = 0; k < 20; k++) v[k] = (b[k] != 0);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: remaining preamble cycles, remaining frame bits, remaining gap cycles
  bit          m_on   [2];
  int          m_sync [2];
  int          m_gap  [2];
  int          m_left [2];
  logic        m_out  [2];
  logic [19:0] m_fr   [2];
  bit          m_live = 1'b0;

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic bit m_idle(input int i);
    return m_sync[i] == 0 && m_gap[i] == 0 && !m_on[i];
  endfunction

  function automatic bit m_ready(input int i);
    return m_idle(i) || (gap_of(i) == 0 && m_on[i] && m_left[i] == 0);
  endfunction

  // Each negedge: compare DUT outputs with the model, then advance the model by the coming edge
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("out_g0",   out0,   m_out[0]);
        chk("ready_g0", ready0, m_ready(0));
        chk("busy_g0",  busy0,  !m_idle(0));
        chk("out_g3",   out3,   m_out[1]);
        chk("ready_g3", ready3, m_ready(1));
        chk("busy_g3",  busy3,  !m_idle(1));
      end
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          m_sync[i] = SYNC; m_gap[i] = 0; m_left[i] = 0; m_on[i] = 1'b0; m_out[i] = 1'b0;
        end else if (m_live) begin
          bit acc;
          acc = valid && m_ready(i);
          if (m_sync[i] > 0) begin
            m_sync[i]--; m_out[i] = 1'b0;
          end else if (acc) begin
            m_fr[i] = frame_of(din); m_out[i] = m_fr[i][0]; m_fr[i] = m_fr[i] >> 1;
            m_left[i] = 19; m_on[i] = 1'b1;
          end else if (m_gap[i] > 0) begin
            m_gap[i]--; m_out[i] = 1'b0;
          end else if (m_on[i] && m_left[i] > 0) begin
            m_out[i] = m_fr[i][0]; m_fr[i] = m_fr[i] >> 1; m_left[i]--;
          end else begin
            if (m_on[i]) m_gap[i] = gap_of(i);
            m_on[i] = 1'b0; m_out[i] = 1'b0;
          end
        end
      end
      if (rst) m_live = 1'b1;
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(ready0 && ready3 && !busy0 && !busy3) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk({name, "_timeout"}, n, 0);
  endtask

  int          e1[20] = '{1,1,1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1,0,0};
  int          e2[20] = '{1,1,0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0,0,0};
  int          e3[20] = '{1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0,0};
  logic [59:0] got;
  logic [19:0] one;
  logic [15:0] words[3] = '{16'h0000, 16'h8001, 16'h7FFE};
  int          idles[3] = '{0, 2, 5};
  int          n;
  int          zbad;
  logic        par;

  initial begin
`ifdef SLVDS_T_PARITY_EN
    par = 1'b1;
`else
    par = 1'b0;
`endif
    e2[18] = par ? 1 : 0;

    rst = 1'b1; valid = 1'b1; din = 16'hA5C3;
    repeat (3) tick();
    chk("reset_out",   out0,   0);
    chk("reset_ready", ready0, 0);
    chk("reset_busy",  busy0,  1);
    rst = 1'b0;

    n = 0;
    while (!ready0 && n < 40) begin
      chk("sync_out_low", out0, 0);
      tick();
      n++;
    end
    chk("sync_len", n, SYNC);

    for (int t = 1; t <= 60; t++) begin
      tick();
      got[t-1] = out0;
      if (t >= 21 && t <= 23) begin
        chk("gap3_busy",  busy3,  1);
        chk("gap3_ready", ready3, 0);
        chk("gap3_out",   out3,   0);
      end
      if (t == 24) chk("gap3_end_ready", ready3, 1);
      if (t == 1)  din = 16'h1234;
      if (t == 21) din = 16'hFFFF;
      if (t == 60) valid = 1'b0;
    end
    chk("frame_a5c3", got[19:0],  pack(e1));
    chk("frame_1234", got[39:20], pack(e2));
    chk("frame_ffff", got[59:40], pack(e3));

    wait_idle("parity");
    din = 16'h0001; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      one[k-1] = out0;
      if (k < 20) tick();
    end
    chk("parity_d0",       one[2],  1);
    chk("parity_trailer0", one[18], par);
    chk("parity_trailer1", one[19], 0);

    wait_idle("abort");
    din = 16'h0F0F; valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    chk("abort_out",   out0,   0);
    chk("abort_busy",  busy0,  1);
    chk("abort_ready", ready0, 0);
    rst = 1'b0; valid = 1'b1; din = 16'h3C3C;
    n = 0; zbad = 0;
    while (!ready0 && n < 40) begin
      if (out0 !== 1'b0) zbad++;
      tick();
      n++;
    end
    chk("abort_sync_len", n, SYNC);
    chk("abort_sync_zeros", zbad, 0);
    tick();
    valid = 1'b0;
    chk("abort_new_start", out0, 1);

    for (int w = 0; w < 3; w++) begin
      wait_idle("table");
      repeat (idles[w]) tick();
      din = words[w]; valid = 1'b1;
      tick();
      valid = 1'b0; din = ~words[w];
    end
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
